satd_block_sequencer: RTL
=========================

Name: satd_block_sequencer

Overview:
- Top-level sequencer for one 8x8 SATD block pass through the existing datapath: difference stage, horizontal Hadamard stage, vertical Hadamard stage and absolute-sum stage.
- Accepts a block start over a valid/ready handshake, then steps the row index while row data is valid.
- Generates the per-stage enable, select and clear strobes, drains the pipeline and presents a done/valid handshake to the consumer.
- Replaces the free-running row counter currently held in the SATD top.

Parameters:
- ROWS, 8: rows per block (row beats accepted).
- COLS, 8: vertical-transform column passes.
- HT_H_LAT, 1: cycles from the last en_ht_h to a valid horizontal-transform output.
- SUM_LAT, 1: cycles from the last en_sum to a valid sad result.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start_valid, input, 1: request to start a block.
- start_ready, output, 1: sequencer can accept a start.
- row_valid, input, 1: current row of ORG/CUR data is present.
- abort, input, 1: synchronous cancel of the current block.
- row_idx, output, clog2(ROWS): row select for the ORG/CUR slice.
- en_diff, output, 1: difference stage enable.
- en_ht_h, output, 1: horizontal transform enable.
- sel_ht_h, output, 1: horizontal transform row-parity select.
- clr_ht_h, output, 1: horizontal transform clear, active-high.
- en_ht_v, output, 1: vertical transform enable.
- col_idx, output, clog2(COLS): vertical column select.
- clr_ht_v, output, 1: vertical transform clear, active-high.
- en_sum, output, 1: absolute-sum enable.
- clr_sum, output, 1: absolute-sum clear, active-high.
- out_valid, output, 1: sad result valid.
- out_ready, input, 1: consumer accepts the result.
- busy, output, 1: state is not IDLE.
- blocks_done, output, CNT_W: count of completed handshakes.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All registered outputs = 0, including row_idx, col_idx and blocks_done.
  - start_ready forced to 0 while rst is low.
- States: IDLE, CLEAR, ROW, DRAIN, VERT, FLUSH, DONE. All transitions occur on the rising edge of clk.
- IDLE:
  - start_ready = 1.
  - start_valid & start_ready → CLEAR.
- CLEAR (1 cycle):
  - clr_ht_h, clr_ht_v and clr_sum = 1.
  - row_idx = 0.
  - → ROW.
- ROW:
  - en_diff = row_valid (combinational).
  - On row_valid, row_idx increments.
  - On row_valid with row_idx == ROWS-1: row_idx wraps to 0 and state → DRAIN.
  - row_valid low holds row_idx and all enables at 0; no timeout.
- en_ht_h / sel_ht_h timing:
  - en_ht_h = en_diff delayed by 1 cycle (registered).
  - sel_ht_h = LSB of row_idx delayed by 1 cycle, registered alongside en_ht_h.
- DRAIN:
  - Lasts HT_H_LAT cycles (internal down-counter).
  - → VERT.
- VERT:
  - en_ht_v = 1 for exactly COLS cycles.
  - col_idx runs 0..COLS-1, then returns to 0.
  - → FLUSH.
- en_sum = en_ht_v delayed by 1 cycle (registered).
- FLUSH:
  - Lasts SUM_LAT cycles.
  - → DONE.
- DONE:
  - out_valid = 1 and held until out_ready.
  - out_valid & out_ready → IDLE, and blocks_done increments (wraps at 2^CNT_W).
  - start_ready = 0 in DONE; a start presented during DONE is accepted on the first IDLE cycle.
- abort:
  - In any state other than IDLE, abort → CLEAR-free return to IDLE.
  - Next cycle: all enables 0, out_valid 0, counters cleared to 0, and one cycle of clr_ht_h/clr_ht_v/clr_sum = 1.
  - blocks_done is not incremented.
  - abort in IDLE has no effect.
- Priority: abort > out_ready handshake > state progress.
  - abort together with out_ready in DONE counts as an abort.
- busy = (state != IDLE).
- Nominal latency (defaults, row_valid held 1, start accepted at T0):
  - CLEAR at T1; ROW T2–T9; DRAIN T10; VERT T11–T18; FLUSH T19.
  - out_valid first high at T20.
  - en_ht_h high T3–T10; en_sum high T12–T19.
- Reset mid-operation: immediate return to IDLE with reset values; no clear pulse is generated.

Test Plan:
- Nominal block: rst high, start_valid pulse at T0, row_valid=1, out_ready=1 → en_diff T2–T9 with row_idx 0..7; en_ht_h T3–T10 with sel_ht_h 0,1,0,1…; en_ht_v T11–T18 with col_idx 0..7; en_sum T12–T19; out_valid at T20 only; blocks_done=1; start_ready=1 at T21.
- Row stalls: row_valid low on every other cycle in ROW → row_idx advances only on valid cycles; 8 en_diff pulses total; DRAIN starts the cycle after the 8th valid row.
- Output backpressure: out_ready low for 5 cycles in DONE → out_valid held 6 cycles; start_valid held high → start_ready 0 throughout DONE; start accepted on the IDLE cycle; CLEAR on the following cycle.
- Abort: abort at the 4th ROW cycle → next cycle IDLE, busy=0, row_idx=0, one-cycle clr_ht_h=clr_ht_v=clr_sum=1, blocks_done unchanged; a following nominal block completes normally.
- Async reset: rst low mid-VERT (between clock edges) → all outputs 0 immediately, start_ready=0; after release: IDLE, start_ready=1, blocks_done=0.
- Counter wrap: CNT_W=2, 5 back-to-back blocks → blocks_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/satd_block_sequencer.sv
// Block sequencer for one 8x8 SATD pass: start handshake, row stepping, per-stage
// enables/clears, pipeline drain and a done/valid handshake with a completed-block counter.
module satd_block_sequencer #(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned COLS     = 8,
   parameter int unsigned HT_H_LAT = 1,
   parameter int unsigned SUM_LAT  = 1,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned ColW    = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start_valid,
   output logic             o_start_ready,
   input  logic             i_row_valid,
   input  logic             i_abort,
   output logic [RowW-1:0]  o_row_idx,
   output logic             o_en_diff,
   output logic             o_en_ht_h,
   output logic             o_sel_ht_h,
   output logic             o_clr_ht_h,
   output logic             o_en_ht_v,
   output logic [ColW-1:0]  o_col_idx,
   output logic             o_clr_ht_v,
   output logic             o_en_sum,
   output logic             o_clr_sum,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_blocks_done
);

   localparam int unsigned LatMax = (HT_H_LAT > SUM_LAT) ? HT_H_LAT : SUM_LAT;
   localparam int unsigned LatW   = (LatMax > 1) ? $clog2(LatMax) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRow,
      StDrain,
      StVert,
      StFlush,
      StDone
   } state_e;

   state_e           r_state;
   logic [RowW-1:0]  r_row_idx;
   logic [ColW-1:0]  r_col_idx;
   logic [LatW-1:0]  r_lat_cnt;
   logic [CNT_W-1:0] r_blocks_done;
   logic             r_clr;
   logic             r_en_ht_h;
   logic             r_sel_ht_h;
   logic             r_en_ht_v;
   logic             r_en_sum;
   logic             r_out_valid;
   logic             w_en_diff;

   assign w_en_diff = (r_state == StRow) && i_row_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_row_idx     <= '0;
         r_col_idx     <= '0;
         r_lat_cnt     <= '0;
         r_blocks_done <= '0;
         r_clr         <= 1'b0;
         r_en_ht_h     <= 1'b0;
         r_sel_ht_h    <= 1'b0;
         r_en_ht_v     <= 1'b0;
         r_en_sum      <= 1'b0;
         r_out_valid   <= 1'b0;
      end else begin
         r_clr      <= 1'b0;
         r_en_ht_h  <= w_en_diff;
         r_sel_ht_h <= r_row_idx[0];
         r_en_sum   <= r_en_ht_v;
         // Abort wins over everything else, including the result handshake.
         if (i_abort && (r_state != StIdle)) begin
            r_state     <= StIdle;
            r_clr       <= 1'b1;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_lat_cnt   <= '0;
            r_en_ht_h   <= 1'b0;
            r_sel_ht_h  <= 1'b0;
            r_en_ht_v   <= 1'b0;
            r_en_sum    <= 1'b0;
            r_out_valid <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (i_start_valid) begin
                     r_state <= StClear;
                     r_clr   <= 1'b1;
                  end
               end
               StClear: begin
                  r_row_idx <= '0;
                  r_state   <= StRow;
               end
               StRow: begin
                  if (i_row_valid) begin
                     if (r_row_idx == RowW'(ROWS - 1)) begin
                        r_row_idx <= '0;
                        r_lat_cnt <= LatW'(HT_H_LAT - 1);
                        r_state   <= StDrain;
                     end else begin
                        r_row_idx <= r_row_idx + RowW'(1);
                     end
                  end
               end
               StDrain: begin
                  if (r_lat_cnt == '0) begin
                     r_en_ht_v <= 1'b1;
                     r_col_idx <= '0;
                     r_state   <= StVert;
                  end else begin
                     r_lat_cnt <= r_lat_cnt - LatW'(1);
                  end
               end
               StVert: begin
                  if (r_col_idx == ColW'(COLS - 1)) begin
                     r_en_ht_v <= 1'b0;
                     r_col_idx <= '0;
                     r_lat_cnt <= LatW'(SUM_LAT - 1);
                     r_state   <= StFlush;
                  end else begin
                     r_col_idx <= r_col_idx + ColW'(1);
                  end
               end
               StFlush: begin
                  if (r_lat_cnt == '0) begin
                     r_out_valid <= 1'b1;
                     r_state     <= StDone;
                  end else begin
                     r_lat_cnt <= r_lat_cnt - LatW'(1);
                  end
               end
               StDone: begin
                  if (i_out_ready) begin
                     r_out_valid   <= 1'b0;
                     r_blocks_done <= r_blocks_done + CNT_W'(1);
                     r_state       <= StIdle;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // Gated by reset so no start can be taken while the block is held in reset.
   assign o_start_ready = (r_state == StIdle) && i_rst_n;
   assign o_busy        = (r_state != StIdle);
   assign o_row_idx     = r_row_idx;
   assign o_en_diff     = w_en_diff;
   assign o_en_ht_h     = r_en_ht_h;
   assign o_sel_ht_h    = r_sel_ht_h;
   assign o_clr_ht_h    = r_clr;
   assign o_en_ht_v     = r_en_ht_v;
   assign o_col_idx     = r_col_idx;
   assign o_clr_ht_v    = r_clr;
   assign o_en_sum      = r_en_sum;
   assign o_clr_sum     = r_clr;
   assign o_out_valid   = r_out_valid;
   assign o_blocks_done = r_blocks_done;

endmodule
